// File: rtl/regfile_write_queue.sv
// Write-back queue in front of the 32x32 register file: buffers results,
// drains them one per cycle onto the write port and forwards pending values.
module regfile_write_queue #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [4:0]               in_reg,
    input  logic [31:0]              in_data,
    input  logic                     drain_en,
    output logic                     RegWrite,
    output logic [4:0]               WriteRegister,
    output logic [31:0]              WriteData,
    input  logic [4:0]               ReadRegister1,
    input  logic [4:0]               ReadRegister2,
    output logic                     fwd_hit1,
    output logic                     fwd_hit2,
    output logic [31:0]              fwd_data1,
    output logic [31:0]              fwd_data2,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [4:0]    regMem  [DEPTH];
    logic [31:0]   dataMem [DEPTH];

    logic [AW-1:0] wrPtrReg, wrPtrNext;
    logic [AW-1:0] rdPtrReg, rdPtrNext;
    logic [CW-1:0] countReg, countNext;

    logic full;
    logic doPush;
    logic doStore;
    logic doPop;

    assign full     = (countReg == CW'(DEPTH));
    assign empty    = (countReg == '0);
    assign count    = countReg;
    assign in_ready = !full;

    // A push of $zero completes the handshake but occupies no slot.
    assign doPush  = in_valid && in_ready;
    assign doStore = doPush && (in_reg != 5'd0);
    assign doPop   = !empty && drain_en;

    always_comb begin
        wrPtrNext = wrPtrReg;
        rdPtrNext = rdPtrReg;
        countNext = countReg;
        if (doStore) begin
            wrPtrNext = wrPtrReg + AW'(1);
        end
        if (doPop) begin
            rdPtrNext = rdPtrReg + AW'(1);
        end
        case ({doStore, doPop})
            2'b10:   countNext = countReg + CW'(1);
            2'b01:   countNext = countReg - CW'(1);
            default: countNext = countReg;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtrReg <= '0;
            rdPtrReg <= '0;
            countReg <= '0;
        end else begin
            wrPtrReg <= wrPtrNext;
            rdPtrReg <= rdPtrNext;
            countReg <= countNext;
        end
    end

    always_ff @(posedge clk) begin
        if (doStore) begin
            regMem[wrPtrReg]  <= in_reg;
            dataMem[wrPtrReg] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            RegWrite      <= 1'b0;
            WriteRegister <= 5'd0;
            WriteData     <= 32'd0;
        end else if (doPop) begin
            RegWrite      <= 1'b1;
            WriteRegister <= regMem[rdPtrReg];
            WriteData     <= dataMem[rdPtrReg];
        end else begin
            RegWrite      <= 1'b0;
        end
    end

    // Entries viewed by age: offset 0 is the head (oldest), higher offsets are younger.
    logic [4:0]       ageReg  [DEPTH];
    logic [31:0]      ageData [DEPTH];
    logic [DEPTH-1:0] liveMask;
    logic [DEPTH-1:0] hitVec  [2];
    logic [4:0]       rdAddr  [2];
    logic             hitOut  [2];
    logic [31:0]      dataOut [2];

    assign rdAddr[0] = ReadRegister1;
    assign rdAddr[1] = ReadRegister2;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_age
            logic [AW-1:0] slot;
            assign slot          = rdPtrReg + AW'(gi);
            assign ageReg[gi]    = regMem[slot];
            assign ageData[gi]   = dataMem[slot];
            assign liveMask[gi]  = (CW'(gi) < countReg);
            assign hitVec[0][gi] = liveMask[gi] && (ageReg[gi] == rdAddr[0]);
            assign hitVec[1][gi] = liveMask[gi] && (ageReg[gi] == rdAddr[1]);
        end
    endgenerate

    // Priority, lowest to highest: output register, then queue entries oldest
    // to youngest, so the youngest match overrides everything older.
    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            always_comb begin
                hitOut[gi]  = 1'b0;
                dataOut[gi] = 32'd0;
                if (RegWrite && (WriteRegister == rdAddr[gi])) begin
                    hitOut[gi]  = 1'b1;
                    dataOut[gi] = WriteData;
                end
                for (int i = 0; i < DEPTH; i++) begin
                    if (hitVec[gi][i]) begin
                        hitOut[gi]  = 1'b1;
                        dataOut[gi] = ageData[i];
                    end
                end
                if (rdAddr[gi] == 5'd0) begin
                    hitOut[gi]  = 1'b0;
                    dataOut[gi] = 32'd0;
                end
            end
        end
    endgenerate

    assign fwd_hit1  = hitOut[0];
    assign fwd_hit2  = hitOut[1];
    assign fwd_data1 = dataOut[0];
    assign fwd_data2 = dataOut[1];

endmodule
